// File: rtl/cache_pkg.sv
// Shared cache definitions: geometry, refill FSM encoding and line-address helper.
package cache_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int BLOCK_SIZE  = 4;
    localparam int ADDR_WIDTH  = 32;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    // Base byte address of the line containing addr.
    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss handler: optional dirty-victim write-back, then a word-by-word line fetch
// presented to the cache with a one-cycle fetch_enable pulse.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             miss_req,
    input  logic [ADDR_WIDTH-1:0]            miss_addr,
    input  logic                             wb_valid,
    input  logic [ADDR_WIDTH-1:0]            wb_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] wb_data,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] fetch_data,
    output logic                             fetch_enable,
    output logic                             stall,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_ack,
    output logic [1:0]                       state_dbg
);
    import cache_pkg::*;

    // Memory handshake: a beat completes on a rising edge where mem_req && mem_ack.
    // While mem_req is high and mem_ack low, mem_addr/mem_we/mem_wdata are held.
    localparam int CNT_W  = $clog2(BLOCK_SIZE);
    localparam int LINE_W = BLOCK_SIZE * DATA_WIDTH;

    refill_state_t          state, state_next;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_WIDTH-1:0]  fill_base;
    logic [ADDR_WIDTH-1:0]  wb_base;
    logic [LINE_W-1:0]      wb_line;
    logic                   last_beat;

    assign last_beat = (cnt == CNT_W'(BLOCK_SIZE - 1));
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (miss_req) begin
                    state_next = wb_valid ? WB : FILL;
                end
            end
            WB: begin
                if (mem_ack && last_beat) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (mem_ack && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat offset replaces the low address bits, so a beat can never carry into the tag.
    always_comb begin
        stall        = 1'b0;
        fetch_enable = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state)
            IDLE: begin
                stall = miss_req && rst_n;
            end
            WB: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {wb_base[ADDR_WIDTH-1:OFFSET_BITS], cnt, {(OFFSET_BITS-CNT_W){1'b0}}};
                mem_wdata = wb_line[cnt*DATA_WIDTH +: DATA_WIDTH];
            end
            FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {fill_base[ADDR_WIDTH-1:OFFSET_BITS], cnt, {(OFFSET_BITS-CNT_W){1'b0}}};
            end
            DONE: begin
                fetch_enable = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            fill_base  <= '0;
            wb_base    <= '0;
            wb_line    <= '0;
            fetch_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (miss_req) begin
                        fill_base <= line_base(miss_addr);
                        if (wb_valid) begin
                            wb_base <= line_base(wb_addr);
                            wb_line <= wb_data;
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        fetch_data[cnt*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a data=address memory model.
module tb_cache_refill_ctrl;

    logic         clk;
    logic         rst_n;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         wb_valid;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic [127:0] fetch_data;
    logic         fetch_enable;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ack;
    logic [1:0]   state_dbg;

    int tests_run;
    int tests_failed;

    cache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .fetch_data(fetch_data), .fetch_enable(fetch_enable), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .state_dbg(state_dbg)
    );

    // ---------------- clock / memory model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       wait_mode;
    logic [1:0] wcnt;
    always @(posedge clk) wcnt <= (wcnt == 2'd2) ? 2'd0 : wcnt + 2'd1;
    assign mem_ack   = mem_req && (!wait_mode || wcnt == 2'd2);
    assign mem_rdata = mem_addr;

    // ---------------- beat monitor ----------------
    logic [31:0] act_addr_q[$];
    logic        act_we_q[$];
    logic [31:0] act_wdata_q[$];
    int          stab_err;
    logic        prev_wait;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && mem_req &&
                (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
                stab_err++;
            if (mem_req && mem_ack) begin
                act_addr_q.push_back(mem_addr);
                act_we_q.push_back(mem_we);
                act_wdata_q.push_back(mem_wdata);
            end
            prev_wait  = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
        end
    end

    // ---------------- driver ----------------
    logic         stall_log[64];
    logic         fe_log[64];
    logic [127:0] fd_log[64];
    logic [31:0]  exp_q[$];
    logic         exp_we_q[$];
    logic [31:0]  exp_wd_q[$];

    task automatic clear_logs();
        act_addr_q.delete(); act_we_q.delete(); act_wdata_q.delete();
        exp_q.delete(); exp_we_q.delete(); exp_wd_q.delete();
        stab_err = 0;
    endtask

    // Called just after a rising edge; cycle 1 is the cycle miss_req is first high.
    task automatic drive_miss(input logic [31:0] a1, input logic [31:0] a2, input int switch_at,
                              input int drop_at, input logic wbv, input logic [31:0] wba,
                              input logic [127:0] wbd, input int ncyc);
        miss_addr = a1; wb_valid = wbv; wb_addr = wba; wb_data = wbd; miss_req = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            stall_log[c] = stall;
            fe_log[c]    = fetch_enable;
            fd_log[c]    = fetch_data;
            @(posedge clk); #1;
            if (c == switch_at) miss_addr = a2;
            if (c == drop_at) begin
                miss_req = 1'b0;
                wb_valid = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        tests_run++;
        if ({mem_req, stall, fetch_enable, mem_we} !== 4'b0 || fetch_data !== 128'd0 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: req/stall/fe/we=%b fd=%h st=%0d required 0", {mem_req, stall, fetch_enable, mem_we}, fetch_data, state_dbg);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clean_miss();
        clear_logs();
        drive_miss(32'h0000_1234, 32'h0, 0, 1, 1'b0, 32'h0, 128'h0, 8);
        for (int c = 1; c <= 8; c++) begin
            tests_run++;
            if (stall_log[c] !== (c <= 5) || fe_log[c] !== (c == 6)) begin
                tests_failed++;
                $display("FAIL clean_timing c%0d: stall=%b fe=%b required stall=%b fe=%b", c, stall_log[c], fe_log[c], c <= 5, c == 6);
            end
        end
        tests_run++;
        if (fd_log[6] !== {32'h123C, 32'h1238, 32'h1234, 32'h1230}) begin
            tests_failed++;
            $display("FAIL clean_line: got %h required 0000123c000012380000123400001230", fd_log[6]);
        end
        exp_q = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        tests_run++;
        if (act_addr_q.size() != 4) begin
            tests_failed++;
            $display("FAIL clean_beat_count: got %0d required 4", act_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (act_addr_q[i] !== exp_q[i] || act_we_q[i] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL clean_beat%0d: addr=%h we=%b required addr=%h we=0", i, act_addr_q[i], act_we_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_dirty_miss();
        clear_logs();
        drive_miss(32'h0000_0810, 32'h0, 0, 1, 1'b1, 32'h0000_0450,
                   {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 12);
        for (int c = 1; c <= 12; c++) begin
            tests_run++;
            if (stall_log[c] !== (c <= 9) || fe_log[c] !== (c == 10)) begin
                tests_failed++;
                $display("FAIL dirty_timing c%0d: stall=%b fe=%b required stall=%b fe=%b", c, stall_log[c], fe_log[c], c <= 9, c == 10);
            end
        end
        exp_q    = '{32'h450, 32'h454, 32'h458, 32'h45C, 32'h810, 32'h814, 32'h818, 32'h81C};
        exp_we_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_wd_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0, 32'h0, 32'h0};
        tests_run++;
        if (act_addr_q.size() != 8) begin
            tests_failed++;
            $display("FAIL dirty_beat_count: got %0d required 8", act_addr_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (act_addr_q[i] !== exp_q[i] || act_we_q[i] !== exp_we_q[i] ||
                    (exp_we_q[i] && act_wdata_q[i] !== exp_wd_q[i])) begin
                    tests_failed++;
                    $display("FAIL dirty_beat%0d: addr=%h we=%b wd=%h required addr=%h we=%b wd=%h", i,
                             act_addr_q[i], act_we_q[i], act_wdata_q[i], exp_q[i], exp_we_q[i], exp_wd_q[i]);
                end
            end
        end
        tests_run++;
        if (fd_log[10] !== {32'h81C, 32'h818, 32'h814, 32'h810}) begin
            tests_failed++;
            $display("FAIL dirty_line: got %h required 0000081c000008180000081400000810", fd_log[10]);
        end
    endtask

    task automatic test_wait_states();
        int fe_cnt, reads, writes;
        clear_logs();
        wait_mode = 1'b1;
        drive_miss(32'h0000_5678, 32'h0, 0, 1, 1'b1, 32'h0000_7700,
                   {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 40);
        wait_mode = 1'b0;
        fe_cnt = 0; reads = 0; writes = 0;
        for (int c = 1; c <= 40; c++) if (fe_log[c] === 1'b1) fe_cnt++;
        foreach (act_we_q[i]) if (act_we_q[i]) writes++; else reads++;
        tests_run++;
        if (fe_cnt != 1) begin
            tests_failed++;
            $display("FAIL wait_fe_pulses: got %0d required 1", fe_cnt);
        end
        tests_run++;
        if (reads != 4 || writes != 4) begin
            tests_failed++;
            $display("FAIL wait_beats: reads=%0d writes=%0d required 4/4", reads, writes);
        end
        tests_run++;
        if (stab_err != 0) begin
            tests_failed++;
            $display("FAIL wait_stability: %0d changes while waiting, required 0", stab_err);
        end
        tests_run++;
        if (fetch_data !== {32'h567C, 32'h5678, 32'h5674, 32'h5670}) begin
            tests_failed++;
            $display("FAIL wait_line: got %h required 0000567c000056780000567400005670", fetch_data);
        end
    endtask

    task automatic test_reset_mid_fill();
        clear_logs();
        miss_addr = 32'h0000_2228; wb_valid = 1'b0; miss_req = 1'b1;
        @(posedge clk); #1; miss_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (act_addr_q.size() != 2 || mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre: beats=%0d req=%b required 2 and 1", act_addr_q.size(), mem_req);
        end
        rst_n = 1'b0; #1;
        tests_run++;
        if ({mem_req, stall, fetch_enable} !== 3'b0 || fetch_data !== 128'd0) begin
            tests_failed++;
            $display("FAIL rst_async: req/stall/fe=%b fd=%h required 000 and 0", {mem_req, stall, fetch_enable}, fetch_data);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (fetch_enable !== 1'b0 || mem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_after c%0d: fe=%b req=%b required 0 0", c, fetch_enable, mem_req);
            end
        end
        @(posedge clk); #1;
        clear_logs();
        drive_miss(32'h0000_2000, 32'h0, 0, 1, 1'b0, 32'h0, 128'h0, 7);
        tests_run++;
        if (fe_log[6] !== 1'b1 || fd_log[6] !== {32'h200C, 32'h2008, 32'h2004, 32'h2000} || act_addr_q.size() != 4) begin
            tests_failed++;
            $display("FAIL rst_recover: fe=%b line=%h beats=%0d required 1, 0000200c..00002000, 4", fe_log[6], fd_log[6], act_addr_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        drive_miss(32'h0000_3000, 32'h0000_4040, 5, 7, 1'b0, 32'h0, 128'h0, 14);
        for (int c = 1; c <= 14; c++) begin
            tests_run++;
            if (fe_log[c] !== (c == 6 || c == 12)) begin
                tests_failed++;
                $display("FAIL b2b_fe c%0d: got %b required %b", c, fe_log[c], c == 6 || c == 12);
            end
        end
        tests_run++;
        if (stall_log[6] !== 1'b0 || stall_log[7] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_stall: c6=%b c7=%b required 0 1", stall_log[6], stall_log[7]);
        end
        exp_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h4040, 32'h4044, 32'h4048, 32'h404C};
        tests_run++;
        if (act_addr_q.size() != 8) begin
            tests_failed++;
            $display("FAIL b2b_beat_count: got %0d required 8", act_addr_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (act_addr_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_beat%0d: addr=%h required %h", i, act_addr_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (fd_log[6] !== {32'h300C, 32'h3008, 32'h3004, 32'h3000} ||
            fd_log[12] !== {32'h404C, 32'h4048, 32'h4044, 32'h4040}) begin
            tests_failed++;
            $display("FAIL b2b_lines: first=%h second=%h", fd_log[6], fd_log[12]);
        end
    endtask

    task automatic test_line_boundary();
        clear_logs();
        drive_miss(32'hFFFF_FFFC, 32'h0, 0, 1, 1'b0, 32'h0, 128'h0, 7);
        exp_q = '{32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        tests_run++;
        if (act_addr_q.size() != 4) begin
            tests_failed++;
            $display("FAIL edge_beat_count: got %0d required 4", act_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (act_addr_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL edge_beat%0d: addr=%h required %h", i, act_addr_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (fe_log[6] !== 1'b1 || fd_log[6] !== {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'hFFFF_FFF0}) begin
            tests_failed++;
            $display("FAIL edge_line: fe=%b line=%h", fe_log[6], fd_log[6]);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; wb_valid = 1'b0;
        wb_addr = '0; wb_data = '0; wait_mode = 1'b0; wcnt = 2'd0; stab_err = 0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_wait_states();
        test_reset_mid_fill();
        test_back_to_back();
        test_line_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss handler between the 2-way data cache and word-wide main memory.
- On a cache miss, it first writes back the victim line if that line is dirty, then fetches the missing 4-word line one word at a time.
- It presents the assembled line to the cache on fetch_data with a one-cycle fetch_enable pulse.
- It stalls the pipeline for the whole miss sequence.

Parameters:
DATA_WIDTH, 32, word width in bits
BLOCK_SIZE, 4, words per cache line
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_req  in  1  cache miss this cycle (rd_en|wr_en and !hit)
miss_addr  in  ADDR_WIDTH  byte address of the missing access
wb_valid  in  1  victim line is dirty and must be written back
wb_addr  in  ADDR_WIDTH  victim line base address (low 4 bits zero)
wb_data  in  BLOCK_SIZE*DATA_WIDTH  victim line; word i at [i*32+:32]
fetch_data  out  BLOCK_SIZE*DATA_WIDTH  refilled line; word i at [i*32+:32]
fetch_enable  out  1  line valid; one-cycle pulse
stall  out  1  hold the pipeline
mem_req  out  1  memory beat request
mem_we  out  1  1 = write beat, 0 = read beat
mem_addr  out  ADDR_WIDTH  word-aligned beat address
mem_wdata  out  DATA_WIDTH  write-beat data
mem_rdata  in  DATA_WIDTH  read-beat data, valid with mem_ack
mem_ack  in  1  beat complete when sampled high with mem_req

Behaviour:
- Reset (async, rst_n=0): state IDLE, beat counter 0, fetch_data 0, all outputs 0.
  - Reset mid-sequence aborts immediately: mem_req drops, partial line is discarded, no fetch_enable is issued.
- FSM states: IDLE, WB, FILL, DONE.
- IDLE:
  - stall = miss_req (combinational), so the cycle in which the miss is detected is already stalled.
  - On a clock edge with miss_req=1, latch fill_base = {miss_addr[31:4],4'b0}.
  - If wb_valid=1, also latch wb_addr and wb_data, and go to WB; otherwise go to FILL.
  - Beat counter is cleared to 0.
- WB:
  - mem_req=1, mem_we=1, mem_addr = wb_base + 4*cnt, mem_wdata = latched word cnt.
  - On mem_ack: cnt++. After beat BLOCK_SIZE-1: cnt=0, go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = fill_base + 4*cnt.
  - On mem_ack: fetch_data word cnt <= mem_rdata; cnt++. After the last beat, go to DONE.
- DONE:
  - fetch_enable=1 and stall=0 for exactly one cycle, so the cache installs the line on this edge.
  - Then return to IDLE.
  - miss_req in DONE is ignored; the cache hits on the next cycle.
- stall=1 in WB and FILL regardless of other inputs.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ack=0.
  - Zero-wait memory (ack in the same cycle as req) completes one beat per cycle.
  - mem_req stays high across consecutive beats. Any number of wait cycles is tolerated, with no timeout.
- fetch_data holds its value until the next FILL overwrites it.
- The address counter adds 4*cnt into the low 4 bits only, so a beat never carries into the tag and never crosses a line.
- Miss latency with zero-wait memory:
  - 1 (accept) + 4 (FILL) + 1 (DONE) = 6 cycles for a clean miss.
  - 10 cycles for a dirty miss.
- mem_rdata is ignored on write beats. mem_ack is ignored when mem_req=0.

Decomposition:
- Shared package cache_pkg holds:
  - DATA_WIDTH, BLOCK_SIZE, OFFSET_BITS=4;
  - enum refill_state_t {IDLE, WB, FILL, DONE};
  - function line_base(addr).
- The cache module must also use cache_pkg.
- No sub-module is needed; the beat counter and the line assembly register live inline.

Test Plan:
- Clean read miss: miss_addr=0x0000_1234, wb_valid=0, zero-wait memory returning data = address.
  - Read beats at 0x1230, 0x1234, 0x1238, 0x123C.
  - fetch_data = {0x123C,0x1238,0x1234,0x1230} with fetch_enable high in cycle 6; stall high in cycles 1-5.
- Dirty miss: wb_valid=1, wb_addr=0x0000_0450, wb_data words 0xA0..0xA3, miss_addr=0x0000_0810.
  - Write beats 0x450..0x45C carry 0xA0..0xA3 in order, then reads at 0x810..0x81C.
  - fetch_enable in cycle 10.
- Wait states: mem_ack asserted every 3rd cycle.
  - mem_addr and mem_wdata stay constant while waiting.
  - Exactly 4 read beats are issued; fetch_enable is a single-cycle pulse.
- Reset mid-FILL: assert rst_n=0 after 2 read acks.
  - mem_req, stall and fetch_enable drop asynchronously; fetch_data=0.
  - After release, a new miss completes normally.
- Back-to-back misses: miss_req held high through DONE.
  - The second miss is accepted only in the following IDLE cycle; no beat is duplicated or skipped.
- Line boundary: miss_addr=0xFFFF_FFFC.
  - Beats go to 0xFFFF_FFF0..0xFFFF_FFFC with no carry.
